idma_inst64_perf_counters: RTL and testbench

- Downstream consumer of the inst64 per-cycle DMA event vector (dma_events_t).
- Accumulates 15 saturating performance counters: handshakes, stalls, beats, bytes and busy cycles.
- Exposes the counters through a single-cycle-latency read port to the inst64 frontend CSR logic.
- Control is a level enable and a synchronous clear pulse.

---
 rtl/idma_inst64_perf_pkg.sv | 60 ++++++
 rtl/idma_inst64_sat_cnt.sv | 30 +++
 rtl/idma_inst64_perf_counters.sv | 127 ++++++++++++
 tb/tb_idma_inst64_perf_counters.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_inst64_perf_pkg.sv
// Shared constants and types for the inst64 DMA performance counter block.
package idma_inst64_perf_pkg;

    localparam int unsigned PerfCycles       = 0;
    localparam int unsigned PerfBusy         = 1;
    localparam int unsigned PerfAwDone       = 2;
    localparam int unsigned PerfAwStall      = 3;
    localparam int unsigned PerfArDone       = 4;
    localparam int unsigned PerfArStall      = 5;
    localparam int unsigned PerfRDone        = 6;
    localparam int unsigned PerfRStall       = 7;
    localparam int unsigned PerfWDone        = 8;
    localparam int unsigned PerfWStall       = 9;
    localparam int unsigned PerfBDone        = 10;
    localparam int unsigned PerfBytesWritten = 11;
    localparam int unsigned PerfAwBeats      = 12;
    localparam int unsigned PerfArBeats      = 13;
    localparam int unsigned PerfArBytes      = 14;
    localparam int unsigned NumPerfCnt       = 15;

    localparam int unsigned RdAddrWidth = 4;

    typedef enum logic [RdAddrWidth-1:0] {
        IdxCycles       = 4'd0,
        IdxBusy         = 4'd1,
        IdxAwDone       = 4'd2,
        IdxAwStall      = 4'd3,
        IdxArDone       = 4'd4,
        IdxArStall      = 4'd5,
        IdxRDone        = 4'd6,
        IdxRStall       = 4'd7,
        IdxWDone        = 4'd8,
        IdxWStall       = 4'd9,
        IdxBDone        = 4'd10,
        IdxBytesWritten = 4'd11,
        IdxAwBeats      = 4'd12,
        IdxArBeats      = 4'd13,
        IdxArBytes      = 4'd14,
        IdxReserved     = 4'd15
    } perf_cnt_idx_e;

    // Event layout of the inst64 event generator for the default 64-bit data path.
    typedef struct packed {
        logic       dma_busy;
        logic       aw_done;
        logic       aw_stall;
        logic       ar_done;
        logic       ar_stall;
        logic       r_done;
        logic       r_stall;
        logic       w_done;
        logic       w_stall;
        logic       b_done;
        logic [3:0] num_bytes_written;
        logic [7:0] aw_len;
        logic [7:0] ar_len;
        logic [2:0] ar_size;
    } dma_events_default_t;

endpackage

// File: rtl/idma_inst64_sat_cnt.sv
// Saturating accumulator: adds inc_i each cycle, sticks at all-ones on carry-out.
module idma_inst64_sat_cnt #(
    parameter int unsigned CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic [CntWidth-1:0] inc_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                sat_o
);

    logic [CntWidth:0] sum;

    assign sum   = {1'b0, cnt_o} + {1'b0, inc_i};
    assign sat_o = sum[CntWidth] & ~clear_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clear_i) begin
            cnt_o <= '0;
        end else if (sum[CntWidth]) begin
            cnt_o <= '1;
        end else begin
            cnt_o <= sum[CntWidth-1:0];
        end
    end

endmodule

// File: rtl/idma_inst64_perf_counters.sv
// inst64 DMA performance counters with a one-cycle read port.
// Optional sticky overflow flags and irq when IDMA_PERF_OVERFLOW_IRQ_EN is defined.
module idma_inst64_perf_counters
    import idma_inst64_perf_pkg::*;
#(
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned DataWidth = 64,
    parameter type         dma_events_t = dma_events_default_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  dma_events_t            events_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic                   rd_req_i,
    input  logic [RdAddrWidth-1:0] rd_addr_i,
    output logic                   rd_valid_o,
    output logic [CntWidth-1:0]    rd_data_o,
    output logic [NumPerfCnt-1:0]  overflow_o,
    output logic                   irq_o
);

    localparam int unsigned NumBytesW = $clog2(DataWidth/8) + 1;

    dma_events_t           stage_q;
    logic                  stage_en_q;
    logic [CntWidth-1:0]   inc [NumPerfCnt];
    logic [CntWidth-1:0]   cnt [NumPerfCnt];
    logic [NumPerfCnt-1:0] sat;
    logic [CntWidth-1:0]   rd_mux;

    // Disabled cycles load zero increments so the counters freeze one stage later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q    <= '0;
            stage_en_q <= 1'b0;
        end else if (clear_i) begin
            stage_q    <= '0;
            stage_en_q <= 1'b0;
        end else begin
            stage_q    <= enable_i ? events_i : '0;
            stage_en_q <= enable_i;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumPerfCnt; i++) begin
            inc[i] = '0;
        end
        inc[PerfCycles]       = CntWidth'(stage_en_q);
        inc[PerfBusy]         = CntWidth'(stage_q.dma_busy);
        inc[PerfAwDone]       = CntWidth'(stage_q.aw_done);
        inc[PerfAwStall]      = CntWidth'(stage_q.aw_stall);
        inc[PerfArDone]       = CntWidth'(stage_q.ar_done);
        inc[PerfArStall]      = CntWidth'(stage_q.ar_stall);
        inc[PerfRDone]        = CntWidth'(stage_q.r_done);
        inc[PerfRStall]       = CntWidth'(stage_q.r_stall);
        inc[PerfWDone]        = CntWidth'(stage_q.w_done);
        inc[PerfWStall]       = CntWidth'(stage_q.w_stall);
        inc[PerfBDone]        = CntWidth'(stage_q.b_done);
        inc[PerfBytesWritten] = CntWidth'(stage_q.num_bytes_written[NumBytesW-1:0]);
        if (stage_q.aw_done) begin
            inc[PerfAwBeats] = CntWidth'(stage_q.aw_len) + CntWidth'(1);
        end
        if (stage_q.ar_done) begin
            inc[PerfArBeats] = CntWidth'(stage_q.ar_len) + CntWidth'(1);
            inc[PerfArBytes] = (CntWidth'(stage_q.ar_len) + CntWidth'(1)) << stage_q.ar_size;
        end
    end

    for (genvar g = 0; g < NumPerfCnt; g++) begin : gen_cnt
        idma_inst64_sat_cnt #(
            .CntWidth(CntWidth)
        ) i_sat_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .clear_i(clear_i),
            .inc_i  (inc[g]),
            .cnt_o  (cnt[g]),
            .sat_o  (sat[g])
        );
    end

    // Index 15 has no counter behind it and reads as zero.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NumPerfCnt; i++) begin
            if (rd_addr_i == RdAddrWidth'(i)) begin
                rd_mux = cnt[i];
            end
        end
    end

    // Read path samples the pre-update value and is not affected by clear_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= rd_mux;
            end
        end
    end

`ifdef IDMA_PERF_OVERFLOW_IRQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= '0;
            irq_o      <= 1'b0;
        end else if (clear_i) begin
            overflow_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            overflow_o <= overflow_o | sat;
            irq_o      <= |overflow_o;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat;
    assign overflow_o = '0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_idma_inst64_perf_counters.sv
// Directed self-checking bench for idma_inst64_perf_counters (CntWidth=16).
module tb_idma_inst64_perf_counters;
    import idma_inst64_perf_pkg::*;

`ifdef IDMA_PERF_OVERFLOW_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic                clk;
    logic                rst;
    dma_events_default_t ev;
    logic                enable;
    logic                clear;
    logic                rd_req;
    logic [3:0]          rd_addr;
    logic                rd_valid;
    logic [15:0]         rd_data;
    logic [14:0]         overflow;
    logic                irq;

    int checks = 0;
    int errors = 0;

    idma_inst64_perf_counters #(
        .CntWidth    (16),
        .DataWidth   (64),
        .dma_events_t(dma_events_default_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .events_i  (ev),
        .enable_i  (enable),
        .clear_i   (clear),
        .rd_req_i  (rd_req),
        .rd_addr_i (rd_addr),
        .rd_valid_o(rd_valid),
        .rd_data_o (rd_data),
        .overflow_o(overflow),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ev = '0;
        repeat (n) tick();
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] d, output logic v);
        ev      = '0;
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        v      = rd_valid;
        d      = rd_data;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        v;
        rst = 1'b1; ev = '0; enable = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0 || overflow !== 15'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%h ovf=%h irq=%0b, expected all 0",
                     rd_valid, rd_data, overflow, irq);
        end
        rst = 1'b0;
        tick();
        enable = 1'b1;
        repeat (10) tick();
        enable = 1'b0;
        tick();
        do_read(4'd0, d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'd10) begin
            errors++;
            $display("FAIL cycles_10: got valid=%0b data=%0d, expected valid=1 data=10", v, d);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'd10) begin
            errors++;
            $display("FAIL valid_low_hold: got valid=%0b data=%0d, expected valid=0 data=10",
                     rd_valid, rd_data);
        end
        for (int a = 1; a < 16; a++) begin
            do_read(4'(a), d, v);
            checks++;
            if (v !== 1'b1 || d !== 16'd0) begin
                errors++;
                $display("FAIL zero_after_reset[%0d]: got valid=%0b data=%0d, expected valid=1 data=0",
                         a, v, d);
            end
        end
    endtask

    task automatic test_aw();
        logic [15:0] d;
        logic        v;
        enable = 1'b1;
        ev = '0; ev.aw_done = 1'b1; ev.aw_len = 8'd7;
        repeat (3) tick();
        idle(2);
        do_read(4'd12, d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'd24) begin
            errors++;
            $display("FAIL aw_beats: got valid=%0b data=%0d, expected valid=1 data=24", v, d);
        end
        do_read(4'd2, d, v);
        checks++;
        if (d !== 16'd3) begin
            errors++;
            $display("FAIL aw_done: got %0d, expected 3", d);
        end
    endtask

    task automatic test_ar();
        logic [15:0] d;
        logic        v;
        ev = '0; ev.ar_done = 1'b1; ev.ar_len = 8'd3; ev.ar_size = 3'd3;
        tick();
        idle(2);
        do_read(4'd14, d, v);
        checks++;
        if (d !== 16'd32) begin
            errors++;
            $display("FAIL ar_bytes: got %0d, expected 32", d);
        end
        do_read(4'd13, d, v);
        checks++;
        if (d !== 16'd4) begin
            errors++;
            $display("FAIL ar_beats: got %0d, expected 4", d);
        end
        do_read(4'd4, d, v);
        checks++;
        if (d !== 16'd1) begin
            errors++;
            $display("FAIL ar_done: got %0d, expected 1", d);
        end
    endtask

    task automatic test_bytes();
        logic [15:0] d;
        logic        v;
        ev = '0; ev.num_bytes_written = 4'd8;
        repeat (2) tick();
        ev.num_bytes_written = 4'd5;
        tick();
        idle(2);
        do_read(4'd11, d, v);
        checks++;
        if (d !== 16'd21) begin
            errors++;
            $display("FAIL bytes_written: got %0d, expected 21", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [4];
        exp_data[0] = 16'd24; exp_data[1] = 16'd4; exp_data[2] = 16'd32; exp_data[3] = 16'd0;
        ev = '0;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 4'(12 + i);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_data[i]) begin
                errors++;
                $display("FAIL b2b_read[%0d]: got valid=%0b data=%0d, expected valid=1 data=%0d",
                         12 + i, rd_valid, rd_data, exp_data[i]);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_clear();
        logic [15:0] d;
        logic        v;
        ev = '0; ev.b_done = 1'b1;
        repeat (2) tick();
        idle(2);
        ev.b_done = 1'b1; clear = 1'b1; rd_req = 1'b1; rd_addr = 4'd10;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'd2) begin
            errors++;
            $display("FAIL clear_concurrent_read: got valid=%0b data=%0d, expected valid=1 data=2",
                     rd_valid, rd_data);
        end
        clear = 1'b0; rd_req = 1'b0;
        idle(2);
        do_read(4'd10, d, v);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL clear_b_done: got %0d, expected 0", d);
        end
        do_read(4'd12, d, v);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL clear_aw_beats: got %0d, expected 0", d);
        end
    endtask

    task automatic test_enable();
        logic [15:0] d;
        logic        v;
        enable = 1'b0;
        ev = '0; ev.dma_busy = 1'b1;
        repeat (5) tick();
        idle(2);
        do_read(4'd1, d, v);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL busy_disabled: got %0d, expected 0", d);
        end
        enable = 1'b1;
        ev.dma_busy = 1'b1;
        repeat (5) tick();
        idle(2);
        do_read(4'd1, d, v);
        checks++;
        if (d !== 16'd5) begin
            errors++;
            $display("FAIL busy_enabled: got %0d, expected 5", d);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic        v;
        logic [14:0] exp_ovf;
        exp_ovf = IrqEn ? 15'h0101 : 15'h0000;
        enable = 1'b0; ev = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1; ev.w_done = 1'b1;
        repeat (65534) tick();
        enable = 1'b0;
        idle(2);
        do_read(4'd8, d, v);
        checks++;
        if (d !== 16'hFFFE || overflow !== 15'h0) begin
            errors++;
            $display("FAIL sat_preload: got data=%h ovf=%h, expected data=fffe ovf=0000", d, overflow);
        end
        enable = 1'b1; ev.w_done = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) begin
                checks++;
                if (overflow !== 15'h0) begin
                    errors++;
                    $display("FAIL ovf_early: got %h, expected 0000", overflow);
                end
            end
            if (i == 3) begin
                checks++;
                if (overflow !== exp_ovf || irq !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_set: got ovf=%h irq=%0b, expected ovf=%h irq=0",
                             overflow, irq, exp_ovf);
                end
            end
            if (i == 4) begin
                checks++;
                if (irq !== IrqEn) begin
                    errors++;
                    $display("FAIL irq_rise: got %0b, expected %0b", irq, IrqEn);
                end
            end
        end
        enable = 1'b0;
        idle(2);
        do_read(4'd8, d, v);
        checks++;
        if (d !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_w_done: got %h, expected ffff", d);
        end
        do_read(4'd0, d, v);
        checks++;
        if (d !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_cycles: got %h, expected ffff", d);
        end
        do_read(4'd9, d, v);
        checks++;
        if (d !== 16'h0 || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL sat_neighbour: got data=%h ovf=%h, expected data=0000 ovf=%h",
                     d, overflow, exp_ovf);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] d;
        logic        v;
        enable = 1'b1;
        ev = '0; ev.aw_done = 1'b1;
        rd_req = 1'b1; rd_addr = 4'd8;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0 || overflow !== 15'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b data=%h ovf=%h irq=%0b, expected all 0",
                     rd_valid, rd_data, overflow, irq);
        end
        rd_req = 1'b0; ev = '0;
        tick();
        rst = 1'b0;
        tick();
        do_read(4'd8, d, v);
        checks++;
        if (d !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_w_done: got %h, expected 0000", d);
        end
        do_read(4'd2, d, v);
        checks++;
        if (d !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_aw_done: got %h, expected 0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_aw();
        test_ar();
        test_bytes();
        test_back_to_back();
        test_clear();
        test_enable();
        test_saturation();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
